// File: rtl/mul_arb_pkg.sv
// Shared widths and defaults for the shared-multiplier arbiter.
// Operand and product widths are fixed; NREQ_DEF seeds the requester count.
package mul_arb_pkg;
    localparam int OPW      = 8;
    localparam int PRW      = 16;
    localparam int NREQ_DEF = 4;
endpackage

// File: rtl/mul8x8_u.sv
// Unsigned 8x8 multiplier core, full-width product.
// Latency: combinational.
// Backpressure: none.
module mul8x8_u
    import mul_arb_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PRW-1:0] p
);

    assign p = PRW'(a) * PRW'(b);

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping mod NREQ.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr < NREQ, so a single subtraction wraps the rotated index
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (!any && valid[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter feeding one shared 8x8 multiplier through a 2-stage pipeline.
// Latency: accept at edge k, response valid after edge k+1 (transferred at edge k+2).
// Backpressure: rsp_ready low stalls stage 2, then stage 1, then all req_ready drop.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PRW-1:0]    rsp_data,
    output logic [IDW-1:0]    rsp_id
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            any;

    logic            v1, v2;
    logic [OPW-1:0]  a1, b1;
    logic [IDW-1:0]  id1, id2;
    logic [PRW-1:0]  p2, prod;

    logic            s1_adv, s2_adv, accept;
    logic [OPW-1:0]  a_sel, b_sel;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid   (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    mul8x8_u u_mul (
        .a (a1),
        .b (b1),
        .p (prod)
    );

    assign s2_adv = !v2 || rsp_ready;
    assign s1_adv = !v1 || s2_adv;
    // ready is masked by rst so no handshake can complete during reset
    assign accept    = en && s1_adv && any && !rst;
    assign req_ready = accept ? gnt : '0;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*OPW +: OPW];
                b_sel = req_b[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            id1 <= '0;
            v2  <= 1'b0;
            p2  <= '0;
            id2 <= '0;
        end else begin
            if (accept)
                ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            if (s1_adv) begin
                v1 <= accept;
                if (accept) begin
                    a1  <= a_sel;
                    b1  <= b_sel;
                    id1 <= gnt_idx;
                end
            end
            if (s2_adv) begin
                v2 <= v1;
                if (v1) begin
                    p2  <= prod;
                    id2 <= id1;
                end
            end
        end
    end

    assign rsp_valid = v2;
    assign rsp_data  = p2;
    assign rsp_id    = id2;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed and randomized checks of the shared-multiplier round-robin arbiter.
module tb_mul_share_arb;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_data;
    logic [1:0]    rsp_id;

    int ntests = 0;
    int nfail  = 0;

    mul_share_arb #(.NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id, input logic [15:0] d);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
    endtask

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hff;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // random-phase model state
    logic [N-1:0] pend;
    logic [7:0]   pa [N];
    logic [7:0]   pb [N];
    int           waitc [N];
    int           eptr;
    int           eg;
    int           acc;
    logic         mv1, mv2, ms1, ms2;
    logic [N-1:0] exp_rdy;
    logic [17:0]  q [$];
    logic [17:0]  exp_rsp;

    initial begin
        rst = 1'b1; en = 1'b1; rsp_ready = 1'b1;
        req_valid = '1; req_a = '0; req_b = '0;

        // reset: outputs quiet and no grant even with every requester valid
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk_rsp("rst_rsp", 1'b0, 2'd0, 16'h0000);

        // single request: 3*5 from requester 0
        rst = 1'b0; req_valid = 4'b0001; set_op(0, 8'd3, 8'd5); #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("single_k1_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk_rsp("single_k2", 1'b1, 2'd0, 16'd15);
        tick();
        chk("single_done", 32'(rsp_valid), 32'h0);

        // full load after reset: grants 0,1,2,3,0..., one product per cycle
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 8'(8'h10 + i), 8'd2);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'hf : 4'h0; #1;
            if (c < 8) chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
            tick();
            if (c >= 1 && c <= 8)
                chk_rsp("rr_rsp", 1'b1, 2'((c - 1) % 4), 16'(2 * (16 + (c - 1) % 4)));
        end
        chk("rr_drained", 32'(rsp_valid), 32'h0);

        // backpressure: 5 cycles of rsp_ready=0 under full load
        for (int i = 0; i < N; i++) set_op(i, 8'(8'h20 + i), 8'd3);
        req_valid = 4'hf; rsp_ready = 1'b0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready), (c == 0) ? 32'h1 : (c == 1) ? 32'h2 : 32'h0);
            if (req_ready != '0) acc++;
            tick();
            if (c >= 1) chk_rsp("bp_hold", 1'b1, 2'd0, 16'h0060);
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        set_op(2, 8'hff, 8'hff); req_valid = 4'b0100; rsp_ready = 1'b1; #1;
        chk("bp_resume_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk_rsp("bp_rsp1", 1'b1, 2'd1, 16'h0063);
        tick();
        chk_rsp("bp_max", 1'b1, 2'd2, 16'hfe01);
        tick();
        chk("bp_done", 32'(rsp_valid), 32'h0);

        // zero operand
        set_op(3, 8'h00, 8'h77); req_valid = 4'b1000; #1;
        chk("zero_ready", 32'(req_ready), 32'h8);
        tick(); req_valid = '0; tick();
        chk_rsp("zero_rsp", 1'b1, 2'd3, 16'h0000);
        tick();

        // en low: no grants, pipeline drains; then req1 first with ptr=1
        set_op(0, 8'd7, 8'd9); req_valid = 4'b0001; #1;
        chk("en_pre_ready", 32'(req_ready), 32'h1);
        tick();
        en = 1'b0; req_valid = 4'b0110;
        set_op(1, 8'h0b, 8'h0d); set_op(2, 8'd2, 8'd2); #1;
        chk("en_off_ready0", 32'(req_ready), 32'h0);
        tick();
        chk_rsp("en_off_drain", 1'b1, 2'd0, 16'h003f);
        chk("en_off_ready1", 32'(req_ready), 32'h0);
        tick();
        chk("en_off_empty", 32'(rsp_valid), 32'h0);
        en = 1'b1; #1;
        chk("en_on_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100; #1;
        chk("en_on_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk_rsp("en_rsp1", 1'b1, 2'd1, 16'h008f);
        tick();
        chk_rsp("en_rsp2", 1'b1, 2'd2, 16'h0004);
        tick();

        // reset with both stages full discards them
        set_op(0, 8'd9, 8'd9); req_valid = 4'b0001;
        tick(); tick();
        chk("mid_full", 32'(rsp_valid), 32'h1);
        rst = 1'b1; req_valid = 4'b0010; #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk_rsp("mid_rst_rsp", 1'b0, 2'd0, 16'h0000);
        rst = 1'b0; req_valid = 4'b0011;
        set_op(0, 8'd4, 8'd6); set_op(1, 8'd5, 8'd5); #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("post_rst_no_stale", 32'(rsp_valid), 32'h0);
        tick();
        chk_rsp("post_rst_rsp", 1'b1, 2'd0, 16'h0018);
        tick();
        chk("post_rst_done", 32'(rsp_valid), 32'h0);

        // randomized traffic against a reference model
        rst = 1'b1; tick(); rst = 1'b0;
        pend = '0; eptr = 0; mv1 = 1'b0; mv2 = 1'b0;
        for (int i = 0; i < N; i++) begin waitc[i] = 0; pa[i] = '0; pb[i] = '0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1; pa[i] = rnd8(); pb[i] = rnd8();
                end
                set_op(i, pa[i], pb[i]);
            end
            req_valid = pend;
            en        = ($urandom_range(0, 7) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = -1;
            for (int k = 0; k < N; k++)
                if (eg < 0 && pend[(eptr + k) % N]) eg = (eptr + k) % N;
            ms2 = !mv2 || rsp_ready;
            ms1 = !mv1 || ms2;
            exp_rdy = (en && ms1 && eg >= 0) ? 4'(1 << eg) : 4'h0;
            chk("rand_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rand_rsp_valid", 32'(rsp_valid), 32'(mv2));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    ntests++; nfail++;
                    $error("FAIL rand_extra_rsp observed id=%0d data=0x%0h expected none", rsp_id, rsp_data);
                end else begin
                    exp_rsp = q.pop_front();
                    chk("rand_rsp", 32'({rsp_id, rsp_data}), 32'(exp_rsp));
                end
            end
            if (exp_rdy != '0) begin
                q.push_back({2'(eg), 16'(16'(pa[eg]) * 16'(pb[eg]))});
                chk("rand_starve", 32'(waitc[eg] < N), 32'h1);
                for (int i = 0; i < N; i++) if (pend[i] && i != eg) waitc[i]++;
                waitc[eg] = 0; pend[eg] = 1'b0; eptr = (eg + 1) % N;
            end
            if (ms2) mv2 = mv1;
            if (ms1) mv1 = (exp_rdy != '0);
            tick();
        end
        req_valid = '0; rsp_ready = 1'b1; en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    ntests++; nfail++;
                    $error("FAIL drain_extra_rsp observed id=%0d data=0x%0h expected none", rsp_id, rsp_data);
                end else begin
                    exp_rsp = q.pop_front();
                    chk("drain_rsp", 32'({rsp_id, rsp_data}), 32'(exp_rsp));
                end
            end
            tick();
        end
        chk("drain_queue_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
